golomb_k_ctrl: RTL and testbench

GOLOMB_K_CTRL -- requirements
Module: golomb_k_ctrl

---
 rtl/golomb_pkg.sv | 53 +++++
 rtl/golomb_k_calc.sv | 34 +++
 rtl/golomb_k_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_golomb_k_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/golomb_pkg.sv
// Shared constants, types and the statistics update rule for the Golomb
// k-parameter controller.
package golomb_pkg;

   localparam int KMAX        = 14;
   localparam int K_RAW       = 15;
   localparam int GAMMA0_EXP  = 2;
   localparam int GAMMA_STAR  = 6;
   localparam int K_INIT      = 4;
   localparam int SIGMA_W     = 24;
   localparam int GAMMA_W     = 7;

   localparam int GAMMA0      = 1 << GAMMA0_EXP;
   localparam int GAMMA_LIMIT = (1 << GAMMA_STAR) - 1;
   localparam int GAMMA_HALF  = 1 << (GAMMA_STAR - 1);
   localparam int SIGMA0      = ((3 * (1 << (K_INIT + 6)) - 49) * GAMMA0) / 128;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } ctrl_state_e;

   typedef struct packed {
      logic [SIGMA_W-1:0] sigma;
      logic [GAMMA_W-1:0] gamma;
   } band_stats_t;

   // Statistics every band starts from after (re)initialisation.
   function automatic band_stats_t stats_init();
      band_stats_t r;
      r.sigma = SIGMA_W'(SIGMA0);
      r.gamma = GAMMA_W'(GAMMA0);
      return r;
   endfunction

   // Accumulate one residual; once the counter saturates, halve the
   // accumulator (rounded) and restart the counter at its midpoint.
   function automatic band_stats_t stats_update(input band_stats_t s,
                                                input logic [SIGMA_W-1:0] delta);
      band_stats_t      r;
      logic [SIGMA_W:0] sum;
      sum = {1'b0, s.sigma} + {1'b0, delta};
      if (s.gamma < GAMMA_W'(GAMMA_LIMIT)) begin
         r.sigma = SIGMA_W'(sum);
         r.gamma = s.gamma + GAMMA_W'(1);
      end else begin
         r.sigma = SIGMA_W'((sum + (SIGMA_W+1)'(1)) >> 1);
         r.gamma = GAMMA_W'(GAMMA_HALF);
      end
      return r;
   endfunction

endpackage

// File: rtl/golomb_k_calc.sv
// Combinational mapping from a band's accumulator/counter pair to the
// Golomb code parameter k.
module golomb_k_calc
   import golomb_pkg::*;
(
   input  logic [SIGMA_W-1:0] sigma_i,
   input  logic [GAMMA_W-1:0] gamma_i,
   output logic [3:0]         k_o
);

   localparam int T_W = SIGMA_W + 1;

   logic [12:0]    scaled;
   logic [T_W-1:0] thresh;
   logic [T_W-1:0] gamma_shift;

   // Threshold T = sigma + floor(49*gamma/128); k is the largest shift
   // keeping gamma*2^k within T, zero when 2*gamma already exceeds T.
   always_comb begin
      scaled      = 13'(gamma_i) * 13'd49;
      thresh      = T_W'(sigma_i) + T_W'(scaled >> 7);
      gamma_shift = '0;
      k_o         = '0;
      if (T_W'({gamma_i, 1'b0}) <= thresh) begin
         for (int i = 1; i <= KMAX; i++) begin
            gamma_shift = T_W'(gamma_i) << i;
            if (gamma_shift <= thresh) begin
               k_o = 4'(i);
            end
         end
      end
   end

endmodule

// File: rtl/golomb_k_ctrl.sv
// Adaptive Golomb k-parameter controller: keeps per-band statistics in a
// synchronous-read RAM and produces k for each accepted residual one cycle
// after acceptance.
// Optional feature: define KCTRL_FWD_EN to forward the write-back statistics
// to a same-band follower instead of stalling it for one cycle.
module golomb_k_ctrl
   import golomb_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int Z_LEN = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             init_i,
   output logic             busy_o,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH:0]   data_i,
   input  logic [Z_LEN-1:0] z_i,
   input  logic             first_i,
   output logic             en_o,
   output logic [3:0]       k_o,
   output logic [WIDTH:0]   data_o,
   output logic [Z_LEN-1:0] z_o
);

   localparam int DEPTH = 1 << Z_LEN;

   ctrl_state_e      state_q, state_d;
   logic [Z_LEN-1:0] init_addr_q, init_addr_d;

   logic             s1_valid_q, s1_valid_d;
   logic             s1_first_q, s1_first_d;
   logic [WIDTH:0]   s1_data_q, s1_data_d;
   logic [Z_LEN-1:0] s1_z_q, s1_z_d;

   logic             en_q, en_d;
   logic [3:0]       k_q, k_d;
   logic [WIDTH:0]   data_q, data_d;
   logic [Z_LEN-1:0] z_q, z_d;

   band_stats_t      ram_q [DEPTH];
   band_stats_t      rd_q;
   logic             ram_we;
   logic [Z_LEN-1:0] ram_waddr;
   band_stats_t      ram_wdata;

   logic             hazard;
   logic             stall;
   logic             accept;
   band_stats_t      s1_stats;
   band_stats_t      s1_next;
   logic [3:0]       k_calc;

`ifdef KCTRL_FWD_EN
   logic             fwd_q, fwd_d;
   band_stats_t      fwd_stats_q, fwd_stats_d;
`endif

   assign busy_o = (state_q == ST_INIT);
   assign en_o   = en_q;
   assign k_o    = k_q;
   assign data_o = data_q;
   assign z_o    = z_q;

   // Handshake: a same-band follower of a non-first S1 sample would read
   // stale statistics; it is either stalled or served by forwarding.
   always_comb begin
      hazard = valid_i && s1_valid_q && !s1_first_q && (z_i == s1_z_q);
`ifdef KCTRL_FWD_EN
      stall  = 1'b0;
`else
      stall  = hazard;
`endif
      ready_o = (state_q == ST_RUN) && !init_i && !stall;
      accept  = valid_i && ready_o;
   end

   // Statistics seen by the S1 sample and its updated write-back value.
   always_comb begin
`ifdef KCTRL_FWD_EN
      s1_stats = fwd_q ? fwd_stats_q : rd_q;
`else
      s1_stats = rd_q;
`endif
      s1_next = stats_update(s1_stats, SIGMA_W'(s1_data_q));
   end

   golomb_k_calc u_k_calc (
      .sigma_i (s1_stats.sigma),
      .gamma_i (s1_stats.gamma),
      .k_o     (k_calc)
   );

   // RAM write port: initialisation sweep has priority over S1 write-back.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = s1_z_q;
      ram_wdata = s1_next;
      if (state_q == ST_INIT) begin
         ram_we    = 1'b1;
         ram_waddr = init_addr_q;
         ram_wdata = stats_init();
      end else if (s1_valid_q && !s1_first_q) begin
         ram_we = 1'b1;
      end
   end

   // Statistics RAM with a registered read port addressed by the accepted band.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_waddr] <= ram_wdata;
      end
      if (accept) begin
         rd_q <= ram_q[z_i];
      end
   end

   // Next-state logic for the INIT/RUN controller, S1 stage and outputs.
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      case (state_q)
         ST_INIT: begin
            if (init_i) begin
               init_addr_d = '0;
            end else if (init_addr_q == Z_LEN'(DEPTH - 1)) begin
               state_d     = ST_RUN;
               init_addr_d = '0;
            end else begin
               init_addr_d = init_addr_q + Z_LEN'(1);
            end
         end
         default: begin
            if (init_i) begin
               state_d     = ST_INIT;
               init_addr_d = '0;
            end
         end
      endcase

      s1_valid_d = accept;
      s1_first_d = s1_first_q;
      s1_data_d  = s1_data_q;
      s1_z_d     = s1_z_q;
      if (accept) begin
         s1_first_d = first_i;
         s1_data_d  = data_i;
         s1_z_d     = z_i;
      end

      en_d   = s1_valid_q;
      k_d    = k_q;
      data_d = data_q;
      z_d    = z_q;
      if (s1_valid_q) begin
         k_d    = s1_first_q ? 4'(K_RAW) : k_calc;
         data_d = s1_data_q;
         z_d    = s1_z_q;
      end

`ifdef KCTRL_FWD_EN
      fwd_d       = accept && hazard;
      fwd_stats_d = s1_next;
`endif
   end

   // Controller state, S1 stage and registered encoder outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_z_q      <= '0;
         en_q        <= 1'b0;
         k_q         <= '0;
         data_q      <= '0;
         z_q         <= '0;
`ifdef KCTRL_FWD_EN
         fwd_q       <= 1'b0;
         fwd_stats_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         s1_valid_q  <= s1_valid_d;
         s1_first_q  <= s1_first_d;
         s1_data_q   <= s1_data_d;
         s1_z_q      <= s1_z_d;
         en_q        <= en_d;
         k_q         <= k_d;
         data_q      <= data_d;
         z_q         <= z_d;
`ifdef KCTRL_FWD_EN
         fwd_q       <= fwd_d;
         fwd_stats_q <= fwd_stats_d;
`endif
      end
   end

endmodule

// File: tb/tb_golomb_k_ctrl.sv
// Self-checking bench for golomb_k_ctrl: directed scenarios plus random
// traffic, with expected outputs queued at acceptance and checked by a
// monitor whenever en_o is seen.
module tb_golomb_k_ctrl;

   localparam int WIDTH = 16;
   localparam int Z_LEN = 8;
   localparam int DEPTH = 1 << Z_LEN;

   logic             clk = 1'b0;
   logic             rst;
   logic             init_i;
   logic             busy_o;
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH:0]   data_i;
   logic [Z_LEN-1:0] z_i;
   logic             first_i;
   logic             en_o;
   logic [3:0]       k_o;
   logic [WIDTH:0]   data_o;
   logic [Z_LEN-1:0] z_o;

   typedef struct {
      int k;
      int data;
      int z;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   model_sigma [DEPTH];
   int   model_gamma [DEPTH];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   golomb_k_ctrl #(.WIDTH(WIDTH), .Z_LEN(Z_LEN)) dut (
      .clk     (clk),
      .rst     (rst),
      .init_i  (init_i),
      .busy_o  (busy_o),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .z_i     (z_i),
      .first_i (first_i),
      .en_o    (en_o),
      .k_o     (k_o),
      .data_o  (data_o),
      .z_o     (z_o)
   );

   // Free-running clock and cycle counter used for latency checks.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: every band starts at sigma=94, gamma=4.
   function automatic void ref_init();
      for (int b = 0; b < DEPTH; b++) begin
         model_sigma[b] = 94;
         model_gamma[b] = 4;
      end
   endfunction

   function automatic int ref_k(input int s, input int g);
      int t;
      int k;
      t = s + (49 * g) / 128;
      if (2 * g > t) return 0;
      k = 0;
      while (k < 14 && g * (1 << (k + 1)) <= t) k++;
      return k;
   endfunction

   function automatic void ref_update(input int b, input int d);
      if (model_gamma[b] < 63) begin
         model_sigma[b] = model_sigma[b] + d;
         model_gamma[b] = model_gamma[b] + 1;
      end else begin
         model_sigma[b] = (model_sigma[b] + d + 1) / 2;
         model_gamma[b] = 32;
      end
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   // Drive one sample (called just after a rising edge); queue its expected
   // result at acceptance. k_force >= 0 overrides the model with a known value.
   task automatic applyStimulus(input int z, input int data, input bit first,
                                input int k_force, output int stall_cycles);
      exp_t e;
      valid_i      = 1'b1;
      z_i          = Z_LEN'(z);
      data_i       = (WIDTH+1)'(data);
      first_i      = first;
      stall_cycles = 0;
      #1;
      while (!ready_o && stall_cycles < 2000) begin
         @(posedge clk);
         #2;
         stall_cycles++;
      end
      if (!ready_o) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: band %0d never accepted", z);
         valid_i = 1'b0;
         return;
      end
      e.k    = first ? 15 : ref_k(model_sigma[z], model_gamma[z]);
      if (k_force >= 0) e.k = k_force;
      e.data = data;
      e.z    = z;
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
      if (!first) ref_update(z, data);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   // Monitor: compare every presented output against the scoreboard head.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && en_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: k=%0d z=%0d with nothing queued", k_o, z_o);
         end else begin
            e = exp_q.pop_front();
            checkOutput("k_o", int'(k_o), e.k);
            checkOutput("data_o", int'(data_o), e.data);
            checkOutput("z_o", int'(z_o), e.z);
            checkOutput("latency", cyc, e.cyc);
         end
      end
   end

   initial begin : stimulus
      int st;
      int n;
      int z;
      int d;
      int kf;
      bit f;

      rst     = 1'b1;
      init_i  = 1'b0;
      valid_i = 1'b0;
      data_i  = '0;
      z_i     = '0;
      first_i = 1'b0;
      ref_init();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_en", int'(en_o), 0);
      checkOutput("rst_k", int'(k_o), 0);
      checkOutput("rst_data", int'(data_o), 0);
      checkOutput("rst_z", int'(z_o), 0);
      checkOutput("rst_busy", int'(busy_o), 1);
      checkOutput("rst_ready", int'(ready_o), 0);
      rst = 1'b0;
      n = 0;
      while (busy_o && n < 1000) begin
         n++;
         @(negedge clk);
      end
      checkOutput("init_busy_cycles", n, 256);
      checkOutput("ready_after_init", int'(ready_o), 1);
      @(posedge clk);
      #1;

      // Fresh band gives the initial k
      applyStimulus(3, 0, 1'b0, 4, st);
      drain();

      // Raw (first) sample leaves statistics untouched and needs no bubble
      applyStimulus(5, 'h1ABCD, 1'b1, 15, st);
      applyStimulus(5, 0, 1'b0, 4, st);
      checkOutput("first_no_stall", st, 0);
      drain();
      @(negedge clk);
      checkOutput("idle_en", int'(en_o), 0);
      checkOutput("idle_hold_k", int'(k_o), 4);
      checkOutput("idle_hold_z", int'(z_o), 5);
      @(posedge clk);
      #1;

      // Back-to-back same band: bubble or forwarding
      applyStimulus(7, 1000, 1'b0, 4, st);
      applyStimulus(7, 0, 1'b0, 7, st);
`ifdef KCTRL_FWD_EN
      checkOutput("hazard_bubble", st, 0);
`else
      checkOutput("hazard_bubble", st, 1);
`endif
      drain();

      // Counter growth drives k down to zero
      for (int i = 1; i <= 56; i++) begin
         kf = (i == 55) ? 1 : ((i == 56) ? 0 : -1);
         applyStimulus(2, 0, 1'b0, kf, st);
      end
      drain();

      // Large residuals hit the k cap
      applyStimulus(4, 'h1FFFF, 1'b0, 4, st);
      applyStimulus(4, 'h1FFFF, 1'b0, 14, st);
      applyStimulus(4, 'h1FFFF, 1'b0, 14, st);
      drain();

      // init_i while a sample sits in S1: it completes, then full re-init
      applyStimulus(7, 1000, 1'b0, -1, st);
      init_i = 1'b1;
      @(posedge clk);
      #1;
      init_i = 1'b0;
      ref_init();
      @(negedge clk);
      n = 0;
      while (busy_o && n < 1000) begin
         n++;
         @(negedge clk);
      end
      checkOutput("reinit_busy_cycles", n, 256);
      @(posedge clk);
      #1;
      applyStimulus(7, 0, 1'b0, 4, st);
      drain();

      // Random traffic concentrated on a few bands to provoke hazards
      for (int i = 0; i < 400; i++) begin
         z = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                         : int'($urandom_range(0, 3));
         d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 'h1FFFF))
                                         : int'($urandom_range(0, 300));
         f = ($urandom_range(0, 7) == 0);
         applyStimulus(z, d, f, -1, st);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      // Reset while a sample is in flight discards it
      applyStimulus(9, 5, 1'b0, -1, st);
      rst = 1'b1;
      exp_q.delete();
      ref_init();
      #2;
      checkOutput("midrst_en", int'(en_o), 0);
      checkOutput("midrst_busy", int'(busy_o), 1);
      checkOutput("midrst_ready", int'(ready_o), 0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (busy_o && n < 1000) begin
         n++;
         @(negedge clk);
      end
      checkOutput("midrst_busy_cycles", n, 256);
      @(posedge clk);
      #1;
      applyStimulus(9, 0, 1'b0, 4, st);
      drain();

      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
